// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and 7-segment lookup for calc_exec_engine.
// The segment table is only referenced when CALC_SEG_EN is defined.
package calc_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_UPDATE = 3'd2;
  localparam logic [2:0] OP_SHOW   = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CONV = 2'd2
  } state_t;

  // Active-high gfedcba patterns; entry 0 in the LSBs, codes 10-15 are blank.
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return SEG_TABLE[digit*7 +: 7];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, BIN_W steps in total.
// The first step is folded into the start cycle so done fires BIN_W-1 cycles after start.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int BIN_W  = 17,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BCD_W = DIGITS*4;
  localparam int CNT_W = $clog2(BIN_W+1);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] w_adj;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                           : r_bcd[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bin  <= {r_bin[BIN_W-1:BIN_W-1] & 1'b0, bin[BIN_W-2:0]} << 1;
        r_bcd  <= {{(BCD_W-1){1'b0}}, bin[BIN_W-1]};
        r_cnt  <= CNT_W'(1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_bin <= {r_bin[BIN_W-2:0], 1'b0};
        r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BIN_W-1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/calc_exec_engine.sv
// Calculator execution engine: STORE/UPDATE/SHOW/CLEAR over valid/ready, shift-add
// multiply, sticky overflow, sequential BCD display. CALC_SEG_EN selects 7-segment output.
module calc_exec_engine
  import calc_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int ACC_W   = 17,
  parameter int MAX_VAL = 99999,
  parameter int DIGITS  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  input  logic [IN_W-1:0]       in_num,
  output logic                  op_ready,
  output logic [ACC_W-1:0]      total,
`ifdef CALC_SEG_EN
  output logic [DIGITS*7-1:0]   disp_out,
`else
  output logic [DIGITS*4-1:0]   disp_out,
`endif
  output logic                  disp_valid,
  output logic                  err
);

  localparam int PROD_W = IN_W + ACC_W;
  localparam int BCD_W  = DIGITS*4;
  localparam int CNT_W  = $clog2(IN_W+1);
`ifdef CALC_SEG_EN
  localparam int DISP_W = DIGITS*7;
`else
  localparam int DISP_W = DIGITS*4;
`endif
  localparam logic [ACC_W:0]    MAX_SUM  = (ACC_W+1)'(MAX_VAL);
  localparam logic [PROD_W-1:0] MAX_PROD = PROD_W'(MAX_VAL);

  state_t              r_state;
  logic                r_op_ready;
  logic [ACC_W-1:0]    r_total;
  logic [ACC_W-1:0]    r_temp;
  logic                r_err;
  logic [DISP_W-1:0]   r_disp;
  logic                r_disp_valid;
  logic [PROD_W-1:0]   r_prod;
  logic [PROD_W-1:0]   r_mcand;
  logic [IN_W-1:0]     r_mplier;
  logic [CNT_W-1:0]    r_mcnt;

  logic                w_accept;
  logic [ACC_W:0]      w_sum;
  logic                w_sum_ovf;
  logic [PROD_W-1:0]   w_prod_next;
  logic [ACC_W-1:0]    w_in_ext;
  logic                w_conv_start;
  logic [ACC_W-1:0]    w_conv_bin;
  logic                w_conv_done;
  logic                w_unused_busy;
  logic [BCD_W-1:0]    w_bcd;
  logic [DISP_W-1:0]   w_disp_next;

  assign w_accept     = op_valid && r_op_ready;
  assign w_sum        = {1'b0, r_total} + {1'b0, r_temp};
  assign w_sum_ovf    = (w_sum > MAX_SUM);
  assign w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_in_ext     = {{(ACC_W-IN_W){1'b0}}, in_num};
  // The converter sees the total that SHOW is about to commit, or the old one on overflow.
  assign w_conv_start = w_accept && (op_code == OP_SHOW) && !r_err;
  assign w_conv_bin   = w_sum_ovf ? r_total : w_sum[ACC_W-1:0];

  bin2bcd_seq #(
    .BIN_W  (ACC_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_conv_start),
    .bin   (w_conv_bin),
    .busy  (w_unused_busy),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  genvar gi;
  generate
`ifdef CALC_SEG_EN
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign w_disp_next[gi*7 +: 7] = seg_encode(w_bcd[gi*4 +: 4]);
    end
`else
    assign w_disp_next = w_bcd;
`endif
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op_ready   <= 1'b1;
      r_total      <= '0;
      r_temp       <= '0;
      r_err        <= 1'b0;
      r_disp       <= '0;
      r_disp_valid <= 1'b0;
      r_prod       <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_mcnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (op_code)
              OP_STORE: begin
                if (!r_err) begin
                  if (w_sum_ovf) begin
                    r_err <= 1'b1;
                  end else begin
                    r_total <= w_sum[ACC_W-1:0];
                    r_temp  <= w_in_ext;
                  end
                end
              end
              OP_UPDATE: begin
                if (!r_err) begin
                  r_prod     <= '0;
                  r_mcand    <= {{IN_W{1'b0}}, r_temp};
                  r_mplier   <= in_num;
                  r_mcnt     <= '0;
                  r_state    <= ST_MUL;
                  r_op_ready <= 1'b0;
                end
              end
              OP_SHOW: begin
                if (!r_err) begin
                  if (w_sum_ovf) begin
                    r_err <= 1'b1;
                  end else begin
                    r_total <= w_sum[ACC_W-1:0];
                    r_temp  <= '0;
                  end
                  r_disp_valid <= 1'b0;
                  r_state      <= ST_CONV;
                  r_op_ready   <= 1'b0;
                end
              end
              OP_CLEAR: begin
                r_total      <= '0;
                r_temp       <= '0;
                r_err        <= 1'b0;
                r_disp       <= '0;
                r_disp_valid <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_mcnt   <= r_mcnt + CNT_W'(1);
          if (r_mcnt == CNT_W'(IN_W-1)) begin
            if (w_prod_next > MAX_PROD) begin
              r_err <= 1'b1;
            end else begin
              r_temp <= w_prod_next[ACC_W-1:0];
            end
            r_state    <= ST_IDLE;
            r_op_ready <= 1'b1;
          end
        end
        ST_CONV: begin
          if (w_conv_done) begin
            r_disp       <= w_disp_next;
            r_disp_valid <= 1'b1;
            r_state      <= ST_IDLE;
            r_op_ready   <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_op_ready <= 1'b1;
        end
      endcase
    end
  end

  assign op_ready   = r_op_ready;
  assign total      = r_total;
  assign disp_out   = r_disp;
  assign disp_valid = r_disp_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_calc_exec_engine.sv
// Self-checking bench for calc_exec_engine: directed vector table, hand-written
// multi-cycle sequences and randomized commands against a decimal arithmetic model.
module tb_calc_exec_engine;

  localparam int IN_W    = 14;
  localparam int ACC_W   = 17;
  localparam int MAX_VAL = 99999;
  localparam int DIGITS  = 5;
`ifdef CALC_SEG_EN
  localparam int DISP_W = DIGITS*7;
`else
  localparam int DISP_W = DIGITS*4;
`endif

  localparam logic [2:0] C_NOP    = 3'd0;
  localparam logic [2:0] C_STORE  = 3'd1;
  localparam logic [2:0] C_UPDATE = 3'd2;
  localparam logic [2:0] C_SHOW   = 3'd3;
  localparam logic [2:0] C_CLEAR  = 3'd4;

  logic               clk;
  logic               reset;
  logic               op_valid;
  logic [2:0]         op_code;
  logic [IN_W-1:0]    in_num;
  logic               op_ready;
  logic [ACC_W-1:0]   total;
  logic [DISP_W-1:0]  disp_out;
  logic               disp_valid;
  logic               err;

  int checks = 0;
  int errors = 0;

  longint      m_total, m_temp;
  bit          m_err, m_dv;
  logic [63:0] m_disp;

  typedef struct {
    logic [2:0] op;
    int         num;
    int         exp_total;
    bit         exp_err;
    int         exp_busy;
    bit         exp_dv;
    int         exp_shown;   // -1: display register cleared
  } vec_t;

  vec_t tbl[$];

  calc_exec_engine #(
    .IN_W    (IN_W),
    .ACC_W   (ACC_W),
    .MAX_VAL (MAX_VAL),
    .DIGITS  (DIGITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .in_num     (in_num),
    .op_ready   (op_ready),
    .total      (total),
    .disp_out   (disp_out),
    .disp_valid (disp_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [63:0] enc_disp(input longint v);
    logic [63:0] r;
    longint x;
    int d;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(x % 10);
      x = x / 10;
`ifdef CALC_SEG_EN
      r[i*7 +: 7] = seg7(d);
`else
      r[i*4 +: 4] = 4'(d);
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: returns the number of cycles op_ready should stay low.
  function automatic int model_apply(input logic [2:0] op, input int num);
    longint s, p;
    case (op)
      C_STORE: begin
        if (!m_err) begin
          s = m_total + m_temp;
          if (s > MAX_VAL) m_err = 1'b1;
          else begin m_total = s; m_temp = num; end
        end
        return 0;
      end
      C_UPDATE: begin
        if (m_err) return 0;
        p = m_temp * num;
        if (p > MAX_VAL) m_err = 1'b1;
        else m_temp = p;
        return IN_W;
      end
      C_SHOW: begin
        if (m_err) return 0;
        s = m_total + m_temp;
        if (s > MAX_VAL) m_err = 1'b1;
        else begin m_total = s; m_temp = 0; end
        m_dv   = 1'b1;
        m_disp = enc_disp(m_total);
        return ACC_W;
      end
      C_CLEAR: begin
        m_total = 0; m_temp = 0; m_err = 1'b0; m_dv = 1'b0; m_disp = '0;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_total = 0; m_temp = 0; m_err = 1'b0; m_dv = 1'b0; m_disp = '0;
  endtask

  task automatic issue(input logic [2:0] op, input int num);
    int g;
    g = 0;
    @(negedge clk);
    while (op_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: op_ready=%b, required 1", op_ready);
    end
    op_valid = 1'b1;
    op_code  = op;
    in_num   = IN_W'(num);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = C_NOP;
    in_num   = '0;
  endtask

  task automatic send(input logic [2:0] op, input int num, output int busy);
    issue(op, num);
    busy = 0;
    while (op_ready !== 1'b1 && busy < 100) begin
      @(posedge clk);
      #1;
      busy++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_total"}, 64'(total), 64'(m_total));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_dv"}, 64'(disp_valid), 64'(m_dv));
    check({tag, "_disp"}, 64'(disp_out), m_disp);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input int num);
    int  exp_busy, busy;
    bit  err_before;
    err_before = m_err;
    exp_busy   = model_apply(op, num);
    send(op, num, busy);
    $display("txn %s op=%0d num=%0d total=%0d err=%0b busy=%0d dv=%0b disp=0x%0h",
             tag, op, num, total, err, busy, disp_valid, disp_out);
    if (!(err_before && (op == C_UPDATE || op == C_SHOW)))
      check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset    = 1'b1;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    $display("txn %s reset total=%0d err=%0b ready=%0b dv=%0b disp=0x%0h",
             tag, total, err, op_ready, disp_valid, disp_out);
    check({tag, "_ready"}, 64'(op_ready), 64'd1);
    check_state(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic void add(input logic [2:0] op, input int num, input int tot, input bit e,
                              input int busy, input bit dv, input int shown);
    vec_t v;
    v.op = op; v.num = num; v.exp_total = tot; v.exp_err = e;
    v.exp_busy = busy; v.exp_dv = dv; v.exp_shown = shown;
    tbl.push_back(v);
  endfunction

  initial begin
    int busy, n, r, num;
    logic [2:0] op;
    logic [63:0] exp_disp;

    reset = 1'b1; op_valid = 1'b0; op_code = C_NOP; in_num = '0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset("init");

    //   op        num    total  err busy    dv shown
    add(C_STORE,  1250,      0, 0, 0,     0, -1);
    add(C_SHOW,      0,   1250, 0, ACC_W, 1, 1250);
    add(C_STORE,  1000,   1250, 0, 0,     1, 1250);
    add(C_UPDATE,    2,   1250, 0, IN_W,  1, 1250);
    add(C_STORE,   100,   3250, 0, 0,     1, 1250);
    add(C_SHOW,      0,   3350, 0, ACC_W, 1, 3350);
    add(C_CLEAR,     0,      0, 0, 0,     0, -1);
    add(C_STORE,  6000,      0, 0, 0,     0, -1);
    add(C_UPDATE,   10,      0, 0, IN_W,  0, -1);
    add(C_STORE,  5000,  60000, 0, 0,     0, -1);
    add(C_UPDATE,   10,  60000, 0, IN_W,  0, -1);
    add(C_SHOW,      0,  60000, 1, ACC_W, 1, 60000);
    add(C_STORE,     5,  60000, 1, 0,     1, 60000);
    add(C_CLEAR,     0,      0, 0, 0,     0, -1);
    add(C_STORE,  9999,      0, 0, 0,     0, -1);
    add(C_UPDATE,   10,      0, 0, IN_W,  0, -1);
    add(C_STORE,     9,  99990, 0, 0,     0, -1);
    add(C_SHOW,      0,  99999, 0, ACC_W, 1, 99999);
    add(C_STORE,     1,  99999, 0, 0,     1, 99999);
    add(C_STORE,     0,  99999, 1, 0,     1, 99999);
    add(C_CLEAR,     0,      0, 0, 0,     0, -1);
    add(C_STORE,   400,      0, 0, 0,     0, -1);
    add(C_UPDATE,  300,      0, 1, IN_W,  0, -1);
    add(C_CLEAR,     0,      0, 0, 0,     0, -1);
    add(C_STORE, 10000,      0, 0, 0,     0, -1);
    add(C_UPDATE,   10,      0, 1, IN_W,  0, -1);
    add(C_CLEAR,     0,      0, 0, 0,     0, -1);
    add(C_STORE, 16383,      0, 0, 0,     0, -1);
    add(C_UPDATE,    6,      0, 0, IN_W,  0, -1);
    add(C_NOP,     123,      0, 0, 0,     0, -1);
    add(3'd5,        7,      0, 0, 0,     0, -1);
    add(3'd7,        1,      0, 0, 0,     0, -1);
    add(C_SHOW,      0,  98298, 0, ACC_W, 1, 98298);
    add(C_STORE,     7,  98298, 0, 0,     1, 98298);
    add(C_UPDATE,    0,  98298, 0, IN_W,  1, 98298);
    add(C_STORE,     1,  98298, 0, 0,     1, 98298);

    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].num, busy);
      exp_disp = (tbl[i].exp_shown < 0) ? 64'd0 : enc_disp(tbl[i].exp_shown);
      $display("txn vec%0d op=%0d num=%0d total=%0d err=%0b busy=%0d dv=%0b disp=0x%0h",
               i, tbl[i].op, tbl[i].num, total, err, busy, disp_valid, disp_out);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      check($sformatf("vec%0d_total", i), 64'(total), 64'(tbl[i].exp_total));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      check($sformatf("vec%0d_dv", i), 64'(disp_valid), 64'(tbl[i].exp_dv));
      check($sformatf("vec%0d_disp", i), 64'(disp_out), exp_disp);
    end

`ifndef CALC_SEG_EN
    check("raw_bcd_98298", 64'(disp_out), 64'h98298);
`endif

    // op_valid held through MUL with a wandering op_code: only the UPDATE is consumed.
    do_reset("held_rst");
    run_cmd("held_store", C_STORE, 3);
    @(negedge clk);
    op_valid = 1'b1; op_code = C_UPDATE; in_num = IN_W'(5);
    @(posedge clk);
    #1;
    void'(model_apply(C_UPDATE, 5));
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      op_code = (n % 2 == 1) ? C_CLEAR : C_SHOW;
      @(posedge clk);
      #1;
      n++;
    end
    op_valid = 1'b0; op_code = C_NOP; in_num = '0;
    $display("txn held_update busy=%0d total=%0d err=%0b", n, total, err);
    check("held_busy", 64'(n), 64'(IN_W));
    check_state("held_after");
    run_cmd("held_commit", C_STORE, 0);

    // Reset in the middle of a multiply.
    run_cmd("rm_store", C_STORE, 1250);
    run_cmd("rm_show", C_SHOW, 0);
    run_cmd("rm_store2", C_STORE, 100);
    issue(C_UPDATE, 3);
    repeat (5) @(posedge clk);
    do_reset("rst_mul");

    // Reset in the middle of a conversion.
    run_cmd("rc_store", C_STORE, 5);
    issue(C_SHOW, 0);
    repeat (6) @(posedge clk);
    do_reset("rst_conv");

    // disp_valid must rise on exactly the ACC_W-th edge after SHOW acceptance.
    run_cmd("d42_store", C_STORE, 42);
    void'(model_apply(C_SHOW, 0));
    issue(C_SHOW, 0);
    repeat (ACC_W-1) begin
      @(posedge clk);
      #1;
    end
    check("d42_dv_early", 64'(disp_valid), 64'd0);
    @(posedge clk);
    #1;
    $display("txn d42_show total=%0d dv=%0b disp=0x%0h", total, disp_valid, disp_out);
    check_state("d42_show");
`ifndef CALC_SEG_EN
    check("d42_raw", 64'(disp_out), 64'h00042);
`endif

    // Randomized commands against the decimal model.
    run_cmd("rnd_clear", C_CLEAR, 0);
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        op  = C_STORE;
        num = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 999);
      end else if (r < 55) begin
        op  = C_UPDATE;
        num = $urandom_range(0, 12);
      end else if (r < 73) begin
        op  = C_SHOW;
        num = $urandom_range(0, 16383);
      end else if (r < 83) begin
        op  = C_CLEAR;
        num = 0;
      end else begin
        op  = ($urandom_range(0, 1) == 0) ? C_NOP : 3'($urandom_range(5, 7));
        num = $urandom_range(0, 16383);
      end
      run_cmd($sformatf("rnd%0d", k), op, num);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
